// File: rtl/vga_timing_pkg.sv
// Shared types and default timing for the VGA raster timing generator.
// Provides the per-axis region encoding, the 640x480@60 default timing
// and a helper that sums the four segments of one axis.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FRONT,
        REG_SYNC,
        REG_BACK
    } region_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Control and video-timing signals of vga_timing_gen.
//   pix_en, restart                      : into the generator
//   hsync, vsync, de, x, y,
//   line_start, frame_start              : out of the generator
// master = the timing generator, slave = whoever drives pix_en and consumes timing.
interface vga_timing_gen_if #(
    parameter int CNT_W = 16
);
    logic             pix_en;
    logic             restart;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  pix_en, restart,
        output hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        output pix_en, restart,
        input  hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter over ACTIVE+FP+SYNC+BP positions.
//   clk, rst_n : clock, async active-low reset
//   step       : advance one position
//   restart    : synchronous return to 0 (wins over step)
//   count      : current position
//   region     : decode of count (active/front/sync/back)
//   wrap       : combinational carry, high when stepping from the last position
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             restart,
    output logic [CNT_W-1:0] count,
    output region_t          region,
    output logic             wrap
);
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        wrap    = step && (count_q == LAST);
        count_d = count_q;
        if (restart || wrap) begin
            count_d = '0;
        end else if (step) begin
            count_d = count_q + CNT_W'(1);
        end

        if (count_q < FRONT_START) begin
            region = REG_ACTIVE;
        end else if (count_q < SYNC_START) begin
            region = REG_FRONT;
        end else if (count_q < BACK_START) begin
            region = REG_SYNC;
        end else begin
            region = REG_BACK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
//   clk, rst_n : clock, async active-low reset
//   vif        : master side of vga_timing_gen_if
//                pix_en advances one pixel, restart returns to (0,0) with idle outputs,
//                hsync/vsync/de/x/y/line_start/frame_start are registered and describe
//                the position the counters held on the previous pix_en.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  vif
);
    localparam longint H_TOTAL = longint'(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam longint V_TOTAL = longint'(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam longint CNT_RANGE = longint'(1) << CNT_W;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end
    if (H_TOTAL > CNT_RANGE || V_TOTAL > CNT_RANGE) begin : g_too_wide
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    region_t          h_region;
    region_t          v_region;
    logic             h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (vif.pix_en),
        .restart (vif.restart),
        .count   (h_count),
        .region  (h_region),
        .wrap    (h_wrap)
    );

    // The vertical axis advances only on the horizontal carry; its own carry is not needed.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (h_wrap),
        .restart (vif.restart),
        .count   (v_count),
        .region  (v_region),
        .wrap    ()
    );

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (vif.restart) begin
            hsync_d = !HS_POL;
            vsync_d = !VS_POL;
            de_d    = 1'b0;
            x_d     = '0;
            y_d     = '0;
        end else if (vif.pix_en) begin
            // Decode the pre-increment position so all outputs describe the same pixel.
            hsync_d       = (h_region == REG_SYNC) ? HS_POL : !HS_POL;
            vsync_d       = (v_region == REG_SYNC) ? VS_POL : !VS_POL;
            de_d          = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
            x_d           = h_count;
            y_d           = v_count;
            line_start_d  = (h_count == '0);
            frame_start_d = (h_count == '0) && (v_count == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= !HS_POL;
            vsync_q       <= !VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 8x6 instance with
// positive sync polarity, both checked every cycle against a linear-pixel-index model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hpol, vpol;
    } mode_t;

    typedef struct {
        logic        hs, vs, de;
        logic [15:0] x, y;
        logic        ls, fs;
    } exp_t;

    localparam mode_t M_DFLT = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    localparam mode_t M_SMALL = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst_n_d;
    logic rst_n_s;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(16)) if_d ();
    vga_timing_gen_if #(.CNT_W(16)) if_s ();

    vga_timing_gen u_dflt (
        .clk   (clk),
        .rst_n (rst_n_d),
        .vif   (if_d.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1), .CNT_W (16)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n_s),
        .vif   (if_s.master)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   p_d, p_s;
    exp_t e_d, e_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    function automatic exp_t idle_of(input mode_t m);
        exp_t r;
        r.hs = !m.hpol; r.vs = !m.vpol; r.de = 1'b0;
        r.x = '0; r.y = '0; r.ls = 1'b0; r.fs = 1'b0;
        return r;
    endfunction

    // Position p is the linear pixel index inside the frame; rows are lines.
    function automatic exp_t pixel_of(input mode_t m, input int p);
        exp_t r;
        int ht, hc, vc;
        ht = m.ha + m.hf + m.hs + m.hb;
        hc = p % ht;
        vc = p / ht;
        r.hs = (hc >= m.ha + m.hf && hc < m.ha + m.hf + m.hs) ? m.hpol : !m.hpol;
        r.vs = (vc >= m.va + m.vf && vc < m.va + m.vf + m.vs) ? m.vpol : !m.vpol;
        r.de = (hc < m.ha) && (vc < m.va);
        r.x  = 16'(hc);
        r.y  = 16'(vc);
        r.ls = (hc == 0);
        r.fs = (p == 0);
        return r;
    endfunction

    function automatic int frame_len(input mode_t m);
        return (m.ha + m.hf + m.hs + m.hb) * (m.va + m.vf + m.vs + m.vb);
    endfunction

    task automatic model_step(input mode_t m, input bit pe, input bit rs,
                              inout int p, inout exp_t e);
        if (rs) begin
            e = idle_of(m);
            p = 0;
        end else if (pe) begin
            e = pixel_of(m, p);
            p = (p + 1) % frame_len(m);
        end else begin
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
    endtask

    task automatic compare_dut(input bit sel);
        exp_t  o, e;
        string n;
        if (sel) begin
            o.hs = if_s.hsync; o.vs = if_s.vsync; o.de = if_s.de; o.x = if_s.x; o.y = if_s.y;
            o.ls = if_s.line_start; o.fs = if_s.frame_start; e = e_s; n = "small";
        end else begin
            o.hs = if_d.hsync; o.vs = if_d.vsync; o.de = if_d.de; o.x = if_d.x; o.y = if_d.y;
            o.ls = if_d.line_start; o.fs = if_d.frame_start; e = e_d; n = "dflt";
        end
        chk({n, ".hsync"},       32'(o.hs), 32'(e.hs));
        chk({n, ".vsync"},       32'(o.vs), 32'(e.vs));
        chk({n, ".de"},          32'(o.de), 32'(e.de));
        chk({n, ".x"},           32'(o.x),  32'(e.x));
        chk({n, ".y"},           32'(o.y),  32'(e.y));
        chk({n, ".line_start"},  32'(o.ls), 32'(e.ls));
        chk({n, ".frame_start"}, 32'(o.fs), 32'(e.fs));
    endtask

    // Called at a negedge: drive, clock, update model, compare at the next negedge.
    task automatic step(input bit sel, input bit pe, input bit rs);
        if (sel) begin
            if_s.pix_en = pe; if_s.restart = rs;
        end else begin
            if_d.pix_en = pe; if_d.restart = rs;
        end
        @(posedge clk);
        if (sel) model_step(M_SMALL, pe, rs, p_s, e_s);
        else     model_step(M_DFLT,  pe, rs, p_d, e_d);
        @(negedge clk);
        compare_dut(sel);
    endtask

    // Pulse reset between edges and check the outputs go idle with no clock edge.
    task automatic async_reset(input bit sel);
        #2;
        if (sel) begin
            rst_n_s = 1'b0; e_s = idle_of(M_SMALL); p_s = 0;
        end else begin
            rst_n_d = 1'b0; e_d = idle_of(M_DFLT); p_d = 0;
        end
        #1;
        compare_dut(sel);
        #1;
        if (sel) rst_n_s = 1'b1;
        else     rst_n_d = 1'b1;
    endtask

    initial begin
        rst_n_d = 1'b0; rst_n_s = 1'b0;
        if_d.pix_en = 1'b1; if_d.restart = 1'b0;
        if_s.pix_en = 1'b1; if_s.restart = 1'b0;
        e_d = idle_of(M_DFLT);  p_d = 0;
        e_s = idle_of(M_SMALL); p_s = 0;
        repeat (3) @(negedge clk);
        compare_dut(1'b0);
        compare_dut(1'b1);

        // Default mode: first pixel, strobe clear, continuous lines, random enables.
        rst_n_d = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1700; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++)
            step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 999) == 0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, 1'b0);
        async_reset(1'b0);
        for (int i = 0; i < 1200; i++) step(1'b0, $urandom_range(0, 1) != 0, 1'b0);

        // Small mode: pix_en every third clock for three frames, then random traffic.
        @(negedge clk);
        rst_n_s = 1'b1;
        for (int i = 0; i < 3 * 144; i++) step(1'b1, (i % 3) == 0, 1'b0);
        for (int i = 0; i < 2000; i++)
            step(1'b1, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        async_reset(1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
